// File: rtl/product_accumulator.sv
// Burst accumulator behind the 32x32 multiplier: sums 64-bit products and presents total/count on a valid/ready port.
// Optional macro PRODUCT_ACC_SATURATE_EN clamps the sum at all-ones instead of wrapping.
module product_accumulator #(
    parameter int unsigned ACC_W = 72,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf;
    logic               ovf_nxt;
    logic               load_out;
    logic [SUM_W-1:0]   sum_ext;
    logic               accept_c;
    logic               done_c;

    assign accept_c = in_valid && in_ready;
    assign done_c   = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM: if (accept_c && in_last) state_nxt = HOLD;
            HOLD:  if (done_c)              state_nxt = ACCUM;
        endcase
    end

    // Datapath next values; the extra sum bit is the carry that drives the sticky overflow
    always_comb begin
        acc_nxt  = acc;
        cnt_nxt  = cnt;
        ovf_nxt  = ovf;
        load_out = 1'b0;
        sum_ext  = {1'b0, acc} + SUM_W'(in_product);
`ifdef PRODUCT_ACC_SATURATE_EN
        acc_add  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_add  = sum_ext[ACC_W-1:0];
`endif
        if (accept_c) begin
            acc_nxt  = acc_add;
            cnt_nxt  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
            ovf_nxt  = ovf | sum_ext[ACC_W];
            load_out = in_last;
        end
        if (done_c) begin
            acc_nxt = '0;
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end
    end

    // Running sum, count and overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    // Registered output port; totals load only on entry to HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == HOLD);
            if (load_out) begin
                out_sum      <= acc_nxt;
                out_count    <= cnt_nxt;
                out_overflow <= ovf_nxt;
            end
        end
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulator directly downstream of the combinational 32×32 `multiplier`. Each accepted beat adds the multiplier's 64-bit unsigned `result` into a widened running sum. On the beat marked last, the block presents the burst total and beat count on a valid/ready output port. It is the consumer stage that turns the multiplier into a dot-product/MAC datapath.

## Interface
- `ACC_W`, 72: accumulator and `out_sum` width; legal range 64..128.
- `CNT_W`, 8: beat-counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  product beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_product`  in  64  unsigned product, wired from multiplier `result`.
- `in_last`  in  1  marks the final beat of a burst; qualified by `in_valid`.
- `out_valid`  out  1  burst total available.
- `out_ready`  in  1  downstream accepts the total.
- `out_sum`  out  ACC_W  burst total.
- `out_count`  out  CNT_W  beats in burst, saturating.
- `out_overflow`  out  1  sum exceeded 2^ACC_W−1 during the burst.

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- A beat is accepted when `in_valid && in_ready`.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - On an accepted beat: `acc <= acc + zero_extend(in_product)`, `cnt <= cnt + 1`, saturating at 2^CNT_W−1.
  - On an accepted beat with `in_last`=1: the updated values load the output registers and the state moves to HOLD.
- HOLD:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`, `out_count` and `out_overflow` stay stable until handshake.
  - On `out_valid && out_ready`: acc, cnt and overflow clear to 0, state returns to ACCUM.
- Overflow: the carry out of the ACC_W-bit add sets the sticky `ovf` flag for the remainder of the burst. `out_overflow` reports it.
- Arithmetic is unsigned. Without saturation the sum wraps modulo 2^ACC_W.
- `in_last` is ignored when `in_valid`=0.
- `in_product`/`in_last` are don't-care while `in_ready`=0. The upstream must hold them with `in_valid` until accepted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0. Internal acc, cnt and ovf are also 0.
- Throughput: one beat per cycle in ACCUM.
- Latency: `out_valid` rises in the cycle after the last beat is accepted.
- HOLD lasts at least one cycle. If `out_ready` is already 1 when HOLD is entered, the block returns to ACCUM on the next edge.
- `in_ready` is 0 for exactly the cycles spent in HOLD. No beat is accepted in the cycle in which the output handshake completes.
- `out_*` change only on entry to HOLD or on reset.
- Reset asserted mid-burst or in HOLD returns the block to reset values immediately. The partial sum is discarded.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined:
  - When the add carries out, acc clamps to 2^ACC_W−1 and stays clamped for the rest of the burst.
  - `out_overflow` is still set.
- Not defined: the sum wraps modulo 2^ACC_W and `out_overflow` flags the wrap.

## Test plan
- Two-beat burst, ACC_W=72: 15 (3×5), then 63 (7×9) with `in_last`, `out_ready`=1 → `out_valid` one cycle after the 2nd beat; `out_sum`=78, `out_count`=2, `out_overflow`=0.
- Single beat 0xFFFF_FFFF_0000_0001 with `in_last` → `out_sum`=0xFFFF_FFFF_0000_0001, `out_count`=1.
- Backpressure: finish a burst summing to 100 and hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out_sum`=100 stable for all 3 cycles. Release `out_ready` → next beat accepted one cycle later and the new sum starts from 0.
- Overflow, ACC_W=64: 0xFFFF_FFFF_FFFF_FFFF then 2 (last) →
  - without macro: `out_sum`=1, `out_overflow`=1;
  - with macro: `out_sum`=0xFFFF_FFFF_FFFF_FFFF, `out_overflow`=1.
- Reset mid-burst: accept 5 and 7, pulse `rst` between clock edges → `in_ready`=1 and `out_valid`=0 immediately; a following burst of 4 (last) gives `out_sum`=4, `out_count`=1.
- Count saturation, CNT_W=2: five beats of 1, last on the 5th → `out_count`=3, `out_sum`=5.
